uart_rx_vote_sampler: RTL and testbench

- Parametrised successor to the UART RX bit sampler.
- Takes a run-time-selectable odd number of samples (1..MAX_SAMPLES), centred on the middle of the bit period, for any legal prescale, not only 4/8/16/32.
- Outputs a registered majority-vote bit with a one-cycle valid strobe, a noise flag and a config-error flag.
- Sits between the RX edge/bit counter and the RX FSM/deserializer. Includes its own RX_IN synchroniser.

---
 rtl/uart_rx_vote_sampler_if.sv | 38 +++
 rtl/uart_rx_vote_sampler.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_vote_sampler.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_vote_sampler_if.sv
// ----------------------------------------------------------------------------
// uart_rx_vote_sampler_if
//
// Bundles the control and result signals between the RX FSM / edge counter
// (master) and the vote sampler (slave). CLK, RST and the raw serial line
// stay as plain ports on the sampler.
//
//   samp_en        master -> slave   sampling enable
//   prescale       master -> slave   clocks per bit
//   samp_num       master -> slave   requested sample count
//   edge_cnt       master -> slave   position within the bit, 0..prescale-1
//   sampled_bit    slave  -> master  registered majority-vote result
//   sampled_valid  slave  -> master  one-cycle strobe, sampled_bit updated
//   noise_flag     slave  -> master  samples were not unanimous
//   cfg_err        slave  -> master  latched configuration is illegal
// ----------------------------------------------------------------------------
interface uart_rx_vote_sampler_if #(
    parameter int PRESCALE_W = 6
);
    logic                  samp_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [3:0]            samp_num;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic                  sampled_bit;
    logic                  sampled_valid;
    logic                  noise_flag;
    logic                  cfg_err;

    modport master (
        output samp_en, prescale, samp_num, edge_cnt,
        input  sampled_bit, sampled_valid, noise_flag, cfg_err
    );

    modport slave (
        input  samp_en, prescale, samp_num, edge_cnt,
        output sampled_bit, sampled_valid, noise_flag, cfg_err
    );
endinterface

// File: rtl/uart_rx_vote_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_vote_sampler
//
// UART RX bit sampler with a run-time selectable, odd-sized majority-vote
// window centred on the middle of the bit period. Works for any prescale.
// The sample count and prescale are latched at the start of every bit
// (edge_cnt == 0 with samp_en high), so mid-bit changes are ignored.
//
// Ports:
//   CLK    system / RX clock
//   RST    asynchronous, active-high reset
//   RX_IN  raw serial line (idle high), asynchronous to CLK
//   bus    uart_rx_vote_sampler_if.slave; control in, vote results out
//
// Parameters:
//   PRESCALE_W   width of prescale and edge_cnt
//   MAX_SAMPLES  largest vote window (odd, 1..15)
//   SYNC_STAGES  RX_IN synchroniser depth, 0 bypasses it
// ----------------------------------------------------------------------------
module uart_rx_vote_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int MAX_SAMPLES = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         RX_IN,
    uart_rx_vote_sampler_if.slave        bus
);

    // Two extra bits keep c + h and the legality sum free of overflow.
    localparam int         CW    = PRESCALE_W + 2;
    localparam logic [3:0] MAX_N = 4'(MAX_SAMPLES);

    // ------------------------------------------------------------------
    // RX_IN synchroniser; resets to the idle (high) line level.
    // ------------------------------------------------------------------
    logic rx_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign rx_s = RX_IN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // NOTE: sequential state uses non-blocking assignments and an
            // async reset in the sensitivity list, so every flop in the
            // block updates from pre-edge values.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= RX_IN;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Configuration helpers
    // ------------------------------------------------------------------
    // Force the requested count odd, then clamp to the largest window.
    function automatic logic [3:0] norm_n(input logic [3:0] req);
        logic [3:0] n;
        n = req | 4'd1;
        if (n > MAX_N) n = MAX_N;
        return n;
    endfunction

    // Window must end at least one clock before the last edge of the bit.
    function automatic logic is_legal(input logic [3:0]            n,
                                      input logic [PRESCALE_W-1:0] p);
        logic [CW-1:0] pe, h, c;
        pe = CW'(p);
        h  = CW'((n - 4'd1) >> 1);
        c  = pe >> 1;
        return (pe >= CW'(4)) && (c + h + CW'(2) <= pe);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]            n_l;
    logic [PRESCALE_W-1:0] p_l;
    logic                  cfg_ok;      // latched config is legal
    logic                  cfg_err_q;
    logic [3:0]            ones;
    logic [3:0]            taken;
    logic                  bit_q;
    logic                  noise_q;
    logic                  valid_q;

    // ------------------------------------------------------------------
    // Window and decision terms
    // ------------------------------------------------------------------
    logic [3:0]    new_n;
    logic          new_legal;
    logic [CW-1:0] h_l, c_l, edge_e;
    logic          latch, in_window, take, decide;
    logic [3:0]    ones_next, taken_next;

    assign new_n     = norm_n(bus.samp_num);
    assign new_legal = is_legal(new_n, bus.prescale);

    assign h_l    = CW'((n_l - 4'd1) >> 1);
    assign c_l    = CW'(p_l) >> 1;
    assign edge_e = CW'(bus.edge_cnt);

    assign latch = bus.samp_en && (bus.edge_cnt == '0);

    // edge >= c - h is written as edge + h >= c so nothing can underflow.
    assign in_window = cfg_ok
                    && (edge_e + h_l >= c_l)
                    && (edge_e <= c_l + h_l);

    assign take = bus.samp_en && in_window;

    // Only a complete window may produce a vote: if samp_en dropped and
    // came back, or the counter entered the window late, the sample count
    // falls short and the bit is silently dropped.
    assign decide = take && (edge_e == c_l + h_l) && (taken_next == n_l);

    always_comb begin
        // NOTE: defaults come first so every path assigns each variable;
        // a missing assignment here would infer a latch.
        ones_next  = ones;
        taken_next = taken;
        if (ones != MAX_N)  ones_next  = ones + {3'b000, rx_s};
        if (taken != MAX_N) taken_next = taken + 4'd1;
    end

    // ------------------------------------------------------------------
    // Config latch
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_l       <= '0;
            p_l       <= '0;
            cfg_ok    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else if (latch) begin
            n_l       <= new_n;
            p_l       <= bus.prescale;
            cfg_ok    <= new_legal;
            cfg_err_q <= !new_legal;
        end
    end

    // ------------------------------------------------------------------
    // Accumulators: cleared at every bit start, whenever sampling is
    // disabled, and after each decision.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ones  <= '0;
            taken <= '0;
        end else if (!bus.samp_en || (bus.edge_cnt == '0) || decide) begin
            ones  <= '0;
            taken <= '0;
        end else if (take) begin
            ones  <= ones_next;
            taken <= taken_next;
        end
    end

    // ------------------------------------------------------------------
    // Vote outputs; bit and noise hold between decisions.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_q   <= 1'b0;
            noise_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= decide;
            if (decide) begin
                bit_q   <= CW'(ones_next) > h_l;
                noise_q <= (ones_next != 4'd0) && (ones_next != n_l);
            end
        end
    end

    assign bus.sampled_bit   = bit_q;
    assign bus.sampled_valid = valid_q;
    assign bus.noise_flag    = noise_q;
    assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_vote_sampler
//
// Drives two sampler instances (synchroniser bypassed and 2-stage) with the
// same bit stream. For each bit the reference model sums the delayed line
// values across the centred window and queues the expected vote; a monitor
// pops the queue whenever a DUT raises sampled_valid and otherwise checks
// that the outputs hold.
// ----------------------------------------------------------------------------
module tb_uart_rx_vote_sampler;

    localparam int PW    = 6;
    localparam int MAXS  = 7;
    localparam int HLEN  = 16384;

    logic CLK   = 1'b0;
    logic RST   = 1'b1;
    logic RX_IN = 1'b1;

    always #5 CLK = ~CLK;

    uart_rx_vote_sampler_if #(.PRESCALE_W(PW)) b0 ();
    uart_rx_vote_sampler_if #(.PRESCALE_W(PW)) b2 ();

    uart_rx_vote_sampler #(.PRESCALE_W(PW), .MAX_SAMPLES(MAXS), .SYNC_STAGES(0)) dut0 (
        .CLK   (CLK),
        .RST   (RST),
        .RX_IN (RX_IN),
        .bus   (b0.slave)
    );

    uart_rx_vote_sampler #(.PRESCALE_W(PW), .MAX_SAMPLES(MAXS), .SYNC_STAGES(2)) dut2 (
        .CLK   (CLK),
        .RST   (RST),
        .RX_IN (RX_IN),
        .bus   (b2.slave)
    );

    typedef struct {
        int   cyc;
        logic bit_v;
        logic noise;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;   // index of the cycle whose inputs are applied
    int   rel_cyc  = 1;   // first cycle after the latest reset release
    logic rx_hist [0:HLEN-1];

    logic last_bit0 = 1'b0, last_noise0 = 1'b0;
    logic last_bit2 = 1'b0, last_noise2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic int model_n(input int sn);
        int n;
        n = sn | 1;
        if (n > MAXS) n = MAXS;
        return n;
    endfunction

    function automatic logic model_legal(input int p, input int sn);
        int h;
        h = (model_n(sn) - 1) / 2;
        return (p >= 4) && (p / 2 + h <= p - 2);
    endfunction

    // Line value seen by the vote logic of a d-stage instance in cycle t.
    function automatic logic rx_s_at(input int t, input int d);
        if (t - d < rel_cyc) return 1'b1;
        return rx_hist[(t - d) % HLEN];
    endfunction

    // Called in the cycle holding the last window sample; the window is the
    // 2h+1 consecutive cycles ending here.
    task automatic push_expect(input int n);
        int   h, ones;
        exp_t e;
        h = (n - 1) / 2;
        for (int d = 0; d <= 2; d += 2) begin
            ones = 0;
            for (int k = 0; k <= 2 * h; k++) ones += int'(rx_s_at(cyc - k, d));
            e.cyc   = cyc;
            e.bit_v = (ones > h);
            e.noise = (ones != 0) && (ones != n);
            if (d == 0) q0.push_back(e);
            else        q2.push_back(e);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic en, input int e, input logic rx, input int p, input int sn);
        @(negedge CLK);
        cyc++;
        b0.samp_en  = en;          b2.samp_en  = en;
        b0.edge_cnt = PW'(e);      b2.edge_cnt = PW'(e);
        b0.prescale = PW'(p);      b2.prescale = PW'(p);
        b0.samp_num = 4'(sn);      b2.samp_num = 4'(sn);
        RX_IN = rx;
        rx_hist[cyc % HLEN] = rx;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid0"}, b0.sampled_valid, 0);
        check({tag, "_bit0"},   b0.sampled_bit,   0);
        check({tag, "_noise0"}, b0.noise_flag,    0);
        check({tag, "_cfg0"},   b0.cfg_err,       0);
        check({tag, "_valid2"}, b2.sampled_valid, 0);
        check({tag, "_bit2"},   b2.sampled_bit,   0);
        check({tag, "_noise2"}, b2.noise_flag,    0);
        check({tag, "_cfg2"},   b2.cfg_err,       0);
        check({tag, "_rx_s2"},  dut2.rx_s,        1);
    endtask

    // One bit period of edge_cnt 0..p-1.
    //   mode 0: normal
    //   mode 1: samp_en low from edge arg to the end of the bit
    //   mode 2: counter jumps from just before the window to just after it
    //   mode 3: reset pulsed at edge arg; the bit is abandoned
    // Mid-bit, prescale and samp_num are scrambled to show they are ignored.
    task automatic run_bit(input int p, input int sn, input int mode, input int arg,
                           input logic [63:0] pat);
        int   n, h, lo, hi, e, sn_mid, p_mid;
        logic legal, en;
        n      = model_n(sn);
        h      = (n - 1) / 2;
        lo     = p / 2 - h;
        hi     = p / 2 + h;
        legal  = model_legal(p, sn);
        sn_mid = $urandom_range(0, 15);
        p_mid  = $urandom_range(1, 63);
        e = 0;
        while (e < p) begin
            en = !((mode == 1) && (e >= arg));
            drive(en, e, pat[e], (e == 0) ? p : p_mid, (e == 0) ? sn : sn_mid);
            if (e == 0) begin
                @(posedge CLK); #1;
                check("cfg_err0", b0.cfg_err, !legal);
                check("cfg_err2", b2.cfg_err, !legal);
            end
            if (mode == 3 && e == arg) begin
                #2 RST = 1'b1;
                #1 check_all_zero("midrst");
                @(posedge CLK); #2 RST = 1'b0;
                rel_cyc = cyc + 1;
                check("rx_s_after_release", dut2.rx_s, 1);
                return;
            end
            if (e == hi && legal && mode != 2 && !(mode == 1 && arg <= hi)) push_expect(n);
            if (mode == 2 && e == lo - 1) e = hi + 1;
            else                          e++;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(posedge CLK) begin
        #1;
        if (RST) begin
            last_bit0 = 1'b0; last_noise0 = 1'b0;
            last_bit2 = 1'b0; last_noise2 = 1'b0;
            q0.delete();
            q2.delete();
        end else begin
            if (b0.sampled_valid === 1'b1) begin
                if (q0.size() == 0) begin
                    check("unexpected_valid0", 1, 0);
                end else begin
                    e0 = q0.pop_front();
                    check("valid_cycle0", cyc, e0.cyc);
                    check("bit0",         b0.sampled_bit, e0.bit_v);
                    check("noise0",       b0.noise_flag,  e0.noise);
                    check("cfg_at_valid0", b0.cfg_err, 0);
                    last_bit0   = e0.bit_v;
                    last_noise0 = e0.noise;
                end
            end else begin
                check("hold_bit0",   b0.sampled_bit, last_bit0);
                check("hold_noise0", b0.noise_flag,  last_noise0);
            end
            if (b2.sampled_valid === 1'b1) begin
                if (q2.size() == 0) begin
                    check("unexpected_valid2", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    check("valid_cycle2", cyc, e2.cyc);
                    check("bit2",         b2.sampled_bit, e2.bit_v);
                    check("noise2",       b2.noise_flag,  e2.noise);
                    check("cfg_at_valid2", b2.cfg_err, 0);
                    last_bit2   = e2.bit_v;
                    last_noise2 = e2.noise;
                end
            end else begin
                check("hold_bit2",   b2.sampled_bit, last_bit2);
                check("hold_noise2", b2.noise_flag,  last_noise2);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int   p, sn, mode, arg, kind;
        logic [63:0] pat;

        b0.samp_en = 1'b0;  b2.samp_en = 1'b0;
        b0.edge_cnt = '0;   b2.edge_cnt = '0;
        b0.prescale = '0;   b2.prescale = '0;
        b0.samp_num = '0;   b2.samp_num = '0;

        repeat (3) @(posedge CLK);
        #1 check_all_zero("reset");
        RST = 1'b0;
        rel_cyc = cyc + 1;

        // P=8, N=3: window 3..5
        run_bit(8, 3, 0, 0, 64'h0000_0000_0000_0028);   // 1,0,1 at 3,4,5
        check("p8_bit0",   b0.sampled_bit, 1);
        check("p8_noise0", b0.noise_flag,  1);
        run_bit(8, 3, 0, 0, 64'h0);
        check("p8_zero_bit0",   b0.sampled_bit, 0);
        check("p8_zero_noise0", b0.noise_flag,  0);
        check("p8_zero_bit2",   b2.sampled_bit, 0);

        // P=16, N=5: window 6..10
        run_bit(16, 5, 0, 0, 64'h0000_0000_0000_0240);  // ones at 6,9
        check("p16_2of5_bit0",   b0.sampled_bit, 0);
        check("p16_2of5_noise0", b0.noise_flag,  1);
        run_bit(16, 5, 0, 0, 64'h0000_0000_0000_0540);  // ones at 6,8,10
        check("p16_3of5_bit0", b0.sampled_bit, 1);

        // P=10, samp_num=4 -> N=5, window 3..7
        run_bit(10, 4, 0, 0, 64'h0000_0000_0000_00F8);
        check("p10_bit0", b0.sampled_bit, 1);
        run_bit(10, 4, 0, 0, 64'h0000_0000_0000_0008);
        check("p10_bit0b", b0.sampled_bit, 0);

        // P=4: N=3 illegal, N=1 legal with the sample at edge 2
        run_bit(4, 3, 0, 0, 64'hF);
        check("p4_cfg_err", b0.cfg_err, 1);
        check("p4_no_vote", b0.sampled_bit, 0);
        run_bit(4, 1, 0, 0, 64'h4);
        check("p4n1_cfg_err", b0.cfg_err, 0);
        check("p4n1_bit0",    b0.sampled_bit, 1);
        check("p4n1_noise0",  b0.noise_flag,  0);

        // samp_en drop at edge 7, then a clean bit with two ones
        run_bit(16, 5, 0, 0, 64'h0);
        run_bit(16, 5, 1, 7, 64'hFFFF);
        check("drop_hold_bit0", b0.sampled_bit, 0);
        run_bit(16, 5, 0, 0, 64'h0600);                 // ones at 9,10
        check("after_drop_bit0",   b0.sampled_bit, 0);
        check("after_drop_noise0", b0.noise_flag,  1);

        // counter skips the whole window
        run_bit(16, 5, 2, 0, 64'hFFFF);
        check("jump_hold_bit0", b0.sampled_bit, 0);

        // reset inside the window, then a full bit
        run_bit(16, 5, 0, 0, 64'hFFFF);
        run_bit(16, 5, 3, 8, 64'hFFFF);
        run_bit(16, 5, 0, 0, 64'hFFFF);
        check("post_rst_bit0", b0.sampled_bit, 1);

        // synchroniser latency
        repeat (4) drive(1'b0, 0, 1'b1, 8, 1);
        drive(1'b0, 0, 1'b0, 8, 1);
        check("bypass_rx_s", dut0.rx_s, 0);
        @(posedge CLK); #1;
        check("sync_1cyc", dut2.rx_s, 1);
        drive(1'b0, 0, 1'b0, 8, 1);
        @(posedge CLK); #1;
        check("sync_2cyc", dut2.rx_s, 0);

        // randomized bits
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) p = $urandom_range(2, 8);
            else                           p = $urandom_range(4, 40);
            sn   = $urandom_range(0, 15);
            mode = 0;
            arg  = 0;
            case ($urandom_range(0, 9))
                7:       begin mode = 1; arg = $urandom_range(1, p - 1); end
                8, 9:    if (model_legal(p, sn)) mode = 2;
                default: mode = 0;
            endcase
            kind = $urandom_range(0, 3);
            case (kind)
                0:       pat = 64'h0;
                1:       pat = '1;
                default: pat = {$urandom, $urandom};
            endcase
            run_bit(p, sn, mode, arg, pat);
        end

        repeat (4) drive(1'b0, 0, 1'b1, 8, 1);
        @(posedge CLK); #2;
        check("pending_q0", q0.size(), 0);
        check("pending_q2", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
